// File: rtl/bus_irq_controller_pkg.sv
// Shared types and constants for the bus interrupt controller.
// No logic, no latency.
// No flow control.
package bus_irq_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAISE   = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    localparam logic [1:0] OFF_PENDING = 2'd0;
    localparam logic [1:0] OFF_ENABLE  = 2'd1;
    localparam logic [1:0] OFF_ID      = 2'd2;
    localparam logic [1:0] OFF_EOI     = 2'd3;

    localparam int MAX_SRC = 8;
    localparam int ID_W    = 3;

    function automatic logic [MAX_SRC-1:0] onehot(input logic [ID_W-1:0] idx);
        logic [MAX_SRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/bus_irq_controller_if.sv
// Bus and interrupt-line bundle between the processor side (master) and the controller (slave).
// Pure wiring, no latency.
// No backpressure: request levels and one-cycle ack pulses only.
interface bus_irq_controller_if #(parameter int N_SRC = 4);
    logic [7:0]       BUS_ADDR;
    logic             BUS_WE;
    logic [N_SRC-1:0] SRC_REQ;
    logic [N_SRC-1:0] SRC_ACK;
    logic             IRQ_RAISE;
    logic             IRQ_ACK;

    modport master (output BUS_ADDR, BUS_WE, SRC_REQ, IRQ_ACK, input SRC_ACK, IRQ_RAISE);
    modport slave  (input BUS_ADDR, BUS_WE, SRC_REQ, IRQ_ACK, output SRC_ACK, IRQ_RAISE);
endinterface

// File: rtl/bus_irq_controller_arbiter.sv
// Picks one eligible interrupt source, fixed priority or round-robin from rr_ptr.
// Combinational, zero latency.
// No backpressure; winner is only consumed when the controller is idle.
module irq_rr_arbiter
    import bus_irq_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int RR_MODE = 1
) (
    input  logic [N_SRC-1:0] eligible,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [ID_W-1:0]  winner,
    output logic             winner_vld
);
    localparam int CW = ID_W + 1;

    logic [MAX_SRC-1:0] elig8;
    logic [CW-1:0]      cand;

    always_comb begin
        elig8             = '0;
        elig8[N_SRC-1:0]  = eligible;
        winner            = '0;
        winner_vld        = 1'b0;
        cand              = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = (RR_MODE != 0) ? ({1'b0, rr_ptr} + CW'(k)) : CW'(k);
            // rr_ptr < N_SRC, so one subtraction is enough to wrap
            if (cand >= CW'(N_SRC)) cand = cand - CW'(N_SRC);
            if (!winner_vld && elig8[cand[ID_W-1:0]]) begin
                winner_vld = 1'b1;
                winner     = cand[ID_W-1:0];
            end
        end
    end
endmodule

// File: rtl/bus_irq_controller.sv
// Latches source requests, masks, arbitrates and raises one processor interrupt; 8-bit register window.
// Request edge -> IRQ_RAISE in 2 cycles; bus read data driven the cycle after the address.
// No backpressure: IRQ_RAISE holds until IRQ_ACK, service holds until an EOI write.
module bus_irq_controller
    import bus_irq_pkg::*;
#(
    parameter int         N_SRC     = 4,
    parameter logic [7:0] BASE_ADDR = 8'hE8,
    parameter int         RR_MODE   = 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    inout  wire  [7:0]           BUS_DATA,
    bus_irq_controller_if.slave  bus
);
    irq_state_t          state;
    logic [N_SRC-1:0]    req_q, pending, enable, rise, ack_clr, eligible;
    logic                hist_vld;
    logic [ID_W-1:0]     id, rr_ptr, winner;
    logic                winner_vld;
    logic [7:0]          offset, rd_mux, rd_dat;
    logic                rd_oe, in_range, wr_hit, rd_hit, eoi_wr;
    logic [MAX_SRC-1:0]  pend8, en8, ack8;
    logic                unused_bits;

    assign offset   = bus.BUS_ADDR - BASE_ADDR;
    assign in_range = offset < 8'd4;
    assign wr_hit   = in_range & bus.BUS_WE;
    assign rd_hit   = in_range & ~bus.BUS_WE;
    assign eoi_wr   = wr_hit && (offset[1:0] == OFF_EOI);

    // hist_vld blocks edge detection on the first cycle after reset, so levels held through reset don't re-latch
    assign rise     = bus.SRC_REQ & ~req_q & {N_SRC{hist_vld}};
    assign eligible = pending & enable;
    assign ack8     = onehot(id);
    assign ack_clr  = (state == RAISE && bus.IRQ_ACK) ? ack8[N_SRC-1:0] : '0;

    assign BUS_DATA    = rd_oe ? rd_dat : 8'bz;
    assign unused_bits = ^{BUS_DATA, ack8};

    always_comb begin
        pend8            = '0;
        pend8[N_SRC-1:0] = pending;
        en8              = '0;
        en8[N_SRC-1:0]   = enable;
        unique case (offset[1:0])
            OFF_PENDING: rd_mux = pend8;
            OFF_ENABLE:  rd_mux = en8;
            OFF_ID:      rd_mux = {(state == SERVICE), 4'b0000, id};
            default:     rd_mux = 8'h00;
        endcase
    end

    irq_rr_arbiter #(.N_SRC(N_SRC), .RR_MODE(RR_MODE)) u_arb (
        .eligible   (eligible),
        .rr_ptr     (rr_ptr),
        .winner     (winner),
        .winner_vld (winner_vld)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            req_q    <= '0;
            hist_vld <= 1'b0;
            pending  <= '0;
            enable   <= '1;
            rd_dat   <= '0;
            rd_oe    <= 1'b0;
        end else begin
            req_q    <= bus.SRC_REQ;
            hist_vld <= 1'b1;
            pending  <= (pending & ~ack_clr) | rise;
            if (wr_hit && offset[1:0] == OFF_ENABLE) enable <= BUS_DATA[N_SRC-1:0];
            rd_oe    <= rd_hit;
            if (rd_hit) rd_dat <= rd_mux;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            id            <= '0;
            rr_ptr        <= '0;
            bus.IRQ_RAISE <= 1'b0;
            bus.SRC_ACK   <= '0;
        end else begin
            bus.SRC_ACK <= '0;
            unique case (state)
                IDLE: if (winner_vld) begin
                    id            <= winner;
                    bus.IRQ_RAISE <= 1'b1;
                    state         <= RAISE;
                end
                RAISE: if (bus.IRQ_ACK) begin
                    bus.SRC_ACK   <= ack8[N_SRC-1:0];
                    rr_ptr        <= (id == ID_W'(N_SRC - 1)) ? '0 : id + ID_W'(1);
                    bus.IRQ_RAISE <= 1'b0;
                    state         <= SERVICE;
                end
                SERVICE: if (eoi_wr) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_irq_controller.sv
// Scoreboard bench: round-robin controller (A) and fixed-priority controller (B) on one shared bus.
// Expected acks and bus read data are queued at issue time and popped by a negedge monitor.
// Undriven bus is pulled up, so a released bus reads 8'hFF.
module tb_bus_irq_controller;
    localparam int         N         = 4;
    localparam logic [7:0] BASE_A    = 8'hE8;
    localparam logic [7:0] BASE_B    = 8'hF0;
    localparam logic [7:0] IDLE_ADDR = 8'h00;

    typedef struct {
        int         at;
        logic [7:0] dat;
        string      nm;
    } rd_exp_t;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       tb_drv = 1'b0;
    logic [7:0] tb_dat = 8'h00;
    wire  [7:0] bus_data;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;

    logic [N-1:0] exp_ack_a[$];
    logic [N-1:0] exp_ack_b[$];
    rd_exp_t      exp_rd[$];

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    bus_irq_controller_if #(.N_SRC(N)) ifa ();
    bus_irq_controller_if #(.N_SRC(N)) ifb ();

    assign ifb.BUS_ADDR = ifa.BUS_ADDR;
    assign ifb.BUS_WE   = ifa.BUS_WE;
    assign bus_data     = tb_drv ? tb_dat : 8'bz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (bus_data[g]);
    end

    bus_irq_controller #(.N_SRC(N), .BASE_ADDR(BASE_A), .RR_MODE(1)) dut_a (
        .CLK(CLK), .RESET(RESET), .BUS_DATA(bus_data), .bus(ifa)
    );
    bus_irq_controller #(.N_SRC(N), .BASE_ADDR(BASE_B), .RR_MODE(0)) dut_b (
        .CLK(CLK), .RESET(RESET), .BUS_DATA(bus_data), .bus(ifb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin : mon
        rd_exp_t    r;
        logic [7:0] exp_bus;
        if (ifa.SRC_ACK != '0) begin
            if (exp_ack_a.size() == 0) chk("src_ack_a_unexpected", 32'(ifa.SRC_ACK), 32'h0);
            else chk("src_ack_a", 32'(ifa.SRC_ACK), 32'(exp_ack_a.pop_front()));
        end
        if (ifb.SRC_ACK != '0) begin
            if (exp_ack_b.size() == 0) chk("src_ack_b_unexpected", 32'(ifb.SRC_ACK), 32'h0);
            else chk("src_ack_b", 32'(ifb.SRC_ACK), 32'(exp_ack_b.pop_front()));
        end
        if (!tb_drv) begin
            exp_bus = 8'hFF;
            if (exp_rd.size() != 0 && exp_rd[0].at == cyc) begin
                r = exp_rd.pop_front();
                exp_bus = r.dat;
                chk(r.nm, 32'(bus_data), 32'(exp_bus));
            end else begin
                chk("bus_released", 32'(bus_data), 32'(exp_bus));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_rd(input logic [7:0] addr, input bit drives, input logic [7:0] exp, input string nm);
        rd_exp_t r;
        ifa.BUS_ADDR = addr;
        ifa.BUS_WE   = 1'b0;
        if (drives) begin
            r.at  = cyc + 1;
            r.dat = exp;
            r.nm  = nm;
            exp_rd.push_back(r);
        end
        step();
        ifa.BUS_ADDR = IDLE_ADDR;
        step();
    endtask

    task automatic bus_wr(input logic [7:0] addr, input logic [7:0] dat);
        ifa.BUS_ADDR = addr;
        ifa.BUS_WE   = 1'b1;
        tb_dat       = dat;
        tb_drv       = 1'b1;
        step();
        ifa.BUS_WE   = 1'b0;
        ifa.BUS_ADDR = IDLE_ADDR;
        tb_drv       = 1'b0;
    endtask

    task automatic wait_raise(input bit sel_b, input int bound, input string nm);
        int n = 0;
        while (!(sel_b ? ifb.IRQ_RAISE : ifa.IRQ_RAISE) && n < bound) begin
            step();
            n++;
        end
        chk(nm, 32'(sel_b ? ifb.IRQ_RAISE : ifa.IRQ_RAISE), 32'h1);
    endtask

    // Processor acks, the serviced source then drops its request level.
    task automatic ack_src(input bit sel_b, input int id);
        logic [N-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        if (sel_b) begin
            exp_ack_b.push_back(oh);
            ifb.IRQ_ACK = 1'b1;
        end else begin
            exp_ack_a.push_back(oh);
            ifa.IRQ_ACK = 1'b1;
        end
        step();
        ifa.IRQ_ACK = 1'b0;
        ifb.IRQ_ACK = 1'b0;
        if (sel_b) ifb.SRC_REQ[id] = 1'b0;
        else       ifa.SRC_REQ[id] = 1'b0;
        chk("irq_drop_after_ack", 32'(sel_b ? ifb.IRQ_RAISE : ifa.IRQ_RAISE), 32'h0);
    endtask

    task automatic serve(input bit sel_b, input int id, input string nm);
        logic [7:0] base;
        base = sel_b ? BASE_B : BASE_A;
        wait_raise(sel_b, 4, nm);
        ack_src(sel_b, id);
        bus_rd(base + 8'd2, 1'b1, 8'h80 | 8'(id), "id_in_service");
        bus_wr(base + 8'd3, 8'h00);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        step();
        step();
        RESET = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.BUS_ADDR = IDLE_ADDR;
        ifa.BUS_WE   = 1'b0;
        ifa.SRC_REQ  = '0;
        ifa.IRQ_ACK  = 1'b0;
        ifb.SRC_REQ  = '0;
        ifb.IRQ_ACK  = 1'b0;
        #2 RESET = 1'b0;
        step();
        step();
        chk("rst_irq_raise_a", 32'(ifa.IRQ_RAISE), 32'h0);
        chk("rst_src_ack_a", 32'(ifa.SRC_ACK), 32'h0);
        chk("rst_irq_raise_b", 32'(ifb.IRQ_RAISE), 32'h0);
        RESET = 1'b1;
        step();
        bus_rd(BASE_A + 8'd0, 1'b1, 8'h00, "rst_pending");
        bus_rd(BASE_A + 8'd1, 1'b1, 8'h0F, "rst_enable");
        bus_rd(BASE_A + 8'd2, 1'b1, 8'h00, "rst_id");

        // single source end-to-end
        ifa.SRC_REQ[1] = 1'b1;
        wait_raise(1'b0, 2, "t1_raise_2cyc");
        bus_rd(BASE_A + 8'd0, 1'b1, 8'h02, "t1_pending");
        ack_src(1'b0, 1);
        bus_rd(BASE_A + 8'd2, 1'b1, 8'h81, "t1_id_service");
        bus_wr(BASE_A + 8'd3, 8'h5A);
        bus_rd(BASE_A + 8'd2, 1'b1, 8'h01, "t1_id_after_eoi");

        // round-robin ordering and wrap from rr_ptr=3
        do_reset();
        ifa.SRC_REQ = 4'b0101;
        serve(1'b0, 0, "t2_rr_first0");
        serve(1'b0, 2, "t2_rr_then2");
        ifa.SRC_REQ = 4'b0101;
        serve(1'b0, 0, "t2_rr_wrap0");
        serve(1'b0, 2, "t2_rr_wrap2");
        ifa.SRC_REQ = 4'b1010;
        serve(1'b0, 3, "t2_rr_ptr3_first");
        serve(1'b0, 1, "t2_rr_then1");

        // fixed priority: lowest index wins even after serving a higher one
        ifb.SRC_REQ[2] = 1'b1;
        serve(1'b1, 2, "t2_fx_single2");
        ifb.SRC_REQ = 4'b1010;
        serve(1'b1, 1, "t2_fx_first1");
        serve(1'b1, 3, "t2_fx_then3");

        // masking keeps the bit pending without raising
        bus_wr(BASE_A + 8'd1, 8'h0E);
        bus_rd(BASE_A + 8'd1, 1'b1, 8'h0E, "t3_enable_rb");
        ifa.SRC_REQ[0] = 1'b1;
        repeat (4) step();
        chk("t3_masked_no_raise", 32'(ifa.IRQ_RAISE), 32'h0);
        bus_rd(BASE_A + 8'd0, 1'b1, 8'h01, "t3_pending_masked");
        bus_wr(BASE_A + 8'd1, 8'h0F);
        wait_raise(1'b0, 3, "t3_unmask_raise");
        ack_src(1'b0, 0);
        bus_rd(BASE_A + 8'd2, 1'b1, 8'h80, "t3_id");

        // no nesting in service; stray ack ignored
        ifa.SRC_REQ[3] = 1'b1;
        repeat (3) step();
        chk("t4_no_nest", 32'(ifa.IRQ_RAISE), 32'h0);
        ifa.IRQ_ACK = 1'b1;
        step();
        ifa.IRQ_ACK = 1'b0;
        step();
        chk("t4_stray_ack", 32'(ifa.IRQ_RAISE), 32'h0);
        bus_rd(BASE_A + 8'd0, 1'b1, 8'h08, "t4_pending");
        bus_rd(BASE_A + 8'd2, 1'b1, 8'h80, "t4_still_service");
        bus_wr(BASE_A + 8'd3, 8'hFF);
        serve(1'b0, 3, "t4_raise3_after_eoi");

        // register window and out-of-range addresses
        bus_rd(BASE_A + 8'd0, 1'b1, 8'h00, "t5_pending");
        bus_rd(BASE_A + 8'd1, 1'b1, 8'h0F, "t5_enable");
        bus_rd(BASE_A + 8'd2, 1'b1, 8'h03, "t5_id");
        bus_rd(BASE_A + 8'd3, 1'b1, 8'h00, "t5_eoi");
        bus_rd(BASE_A + 8'd4, 1'b0, 8'h00, "t5_oor_hi");
        bus_rd(BASE_A - 8'd1, 1'b0, 8'h00, "t5_oor_lo");
        bus_rd(BASE_B + 8'd1, 1'b1, 8'h0F, "t5_b_enable");
        bus_rd(BASE_B + 8'd2, 1'b1, 8'h03, "t5_b_id");

        // asynchronous reset while raising
        bus_wr(BASE_A + 8'd1, 8'h07);
        ifa.SRC_REQ[2] = 1'b1;
        wait_raise(1'b0, 3, "t6_raise");
        #2 RESET = 1'b0;
        #1 chk("t6_async_drop", 32'(ifa.IRQ_RAISE), 32'h0);
        step();
        step();
        RESET = 1'b1;
        repeat (4) step();
        chk("t6_no_relatch", 32'(ifa.IRQ_RAISE), 32'h0);
        bus_rd(BASE_A + 8'd0, 1'b1, 8'h00, "t6_pending");
        bus_rd(BASE_A + 8'd1, 1'b1, 8'h0F, "t6_enable");
        ifa.SRC_REQ[2] = 1'b0;
        step();
        ifa.SRC_REQ[2] = 1'b1;
        serve(1'b0, 2, "t6_new_edge");

        repeat (3) step();
        chk("ack_q_a_empty", 32'(exp_ack_a.size()), 32'h0);
        chk("ack_q_b_empty", 32'(exp_ack_b.size()), 32'h0);
        chk("rd_q_empty", 32'(exp_rd.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
